// File: rtl/izh_pkg.sv
// izh_pkg: shared types and constants for the time-multiplexed Izhikevich array.
//   izh_mode_e  : neuron firing mode (RS, IB, CH, FS)
//   izh_state_e : sweep FSM state encoding
//   MODE_*      : per-mode recovery shift (ASH), coupling shift (BSH),
//                 reset potential (C) and recovery bump (D), indexed by mode
//   V_THRESH / V_REST : spike threshold and resting potential (integer mV)
//   sat_w       : signed saturation of a 64-bit value to a w-bit range
package izh_pkg;

  typedef enum logic [1:0] {
    MODE_RS = 2'd0,
    MODE_IB = 2'd1,
    MODE_CH = 2'd2,
    MODE_FS = 2'd3
  } izh_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FIN   = 2'd3
  } izh_state_e;

  localparam int MODE_ASH [4] = '{6, 6, 6, 3};
  localparam int MODE_BSH [4] = '{2, 2, 2, 2};
  localparam int MODE_C   [4] = '{-65, -55, -50, -65};
  localparam int MODE_D   [4] = '{8, 4, 2, 2};

  localparam int V_THRESH = 30;
  localparam int V_REST   = -65;

  // Clamp x into [-2^(w-1), 2^(w-1)-1]; callers truncate the result to w bits.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x,
                                               input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      sat_w = hi;
    else if (x < lo) sat_w = lo;
    else             sat_w = x;
  endfunction

endpackage

// File: rtl/izh_core.sv
// izh_core: combinational Izhikevich update for one neuron.
//   v, u     : current membrane potential / recovery (signed, F fraction bits)
//   vv       : registered v*v (2W-bit signed)
//   cur      : unsigned input current (integer units, scaled by 2^F here)
//   mode     : firing mode selecting a, b, c, d
//   v_next, u_next : saturated next state (post-spike reset applied)
//   fired    : next potential reached the spike threshold
module izh_core
  import izh_pkg::*;
#(
  parameter int W        = 16,
  parameter int F        = 4,
  parameter int CUR_W    = 8,
  parameter int DT_SHIFT = 1
) (
  input  logic signed [W-1:0]   v,
  input  logic signed [W-1:0]   u,
  input  logic signed [2*W-1:0] vv,
  input  logic [CUR_W-1:0]      cur,
  input  izh_mode_e             mode,
  output logic signed [W-1:0]   v_next,
  output logic signed [W-1:0]   u_next,
  output logic                  fired
);

  // Two guard bits above 2W keep q + 5v + ... free of overflow before saturation.
  localparam int EW = 2 * W + 2;
  localparam logic signed [EW-1:0] K140  = EW'(140 * (2 ** F));
  localparam logic signed [W-1:0]  TH_FX = W'(V_THRESH * (2 ** F));

  logic signed [EW-1:0] ve, ue, vve, cure;
  logic signed [EW-1:0] q, dv, du, vs, us, d_fx, u_spk;
  logic signed [W-1:0]  v_sat, u_sat;
  int ash, bsh, c_val, d_val;

  always_comb begin
    ash   = MODE_ASH[mode];
    bsh   = MODE_BSH[mode];
    c_val = MODE_C[mode];
    d_val = MODE_D[mode];

    ve   = {{(EW - W){v[W-1]}}, v};
    ue   = {{(EW - W){u[W-1]}}, u};
    vve  = {{(EW - 2 * W){vv[2*W-1]}}, vv};
    cure = {{(EW - CUR_W){1'b0}}, cur};

    // 2^-5 + 2^-7 = 0.039, close to the canonical 0.04 coefficient.
    q  = (vve >>> (F + 5)) + (vve >>> (F + 7));
    dv = q + (ve <<< 2) + ve + K140 - ue + (cure <<< F);
    du = ((ve >>> bsh) - ue) >>> ash;

    vs = ve + (dv >>> DT_SHIFT);
    us = ue + (du >>> DT_SHIFT);

    v_sat = W'(sat_w(64'(vs), W));
    u_sat = W'(sat_w(64'(us), W));

    // The spike bump is applied to the pre-update u, not to u_sat.
    d_fx  = EW'(d_val * (2 ** F));
    u_spk = ue + d_fx;

    fired = (v_sat >= TH_FX);
    if (fired) begin
      v_next = W'(c_val * (2 ** F));
      u_next = W'(sat_w(64'(u_spk), W));
    end else begin
      v_next = v_sat;
      u_next = u_sat;
    end
  end

endmodule

// File: rtl/izh_array.sv
// izh_array: N Izhikevich neurons sharing one update datapath.
//   clk, reset        : clock, synchronous active-high reset
//   tick              : start a sweep (ignored while busy)
//   cur_we/addr/data  : per-neuron input current write
//   cfg_we/addr/mode  : per-neuron mode write
//   obs_sel / obs_v   : registered view of v[obs_sel]
//   spike             : spike vector of the last completed sweep
//   busy / done       : sweep in progress / one-cycle end-of-sweep pulse
//
// state | meaning
// IDLE  | waiting for tick
// CALC  | latch v, u, cur, mode of idx; register v*v
// WRITE | write back v', u' and spike bit for idx; advance or finish
// FIN   | publish spike vector, pulse done, drop busy
module izh_array
  import izh_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int F        = 4,
  parameter int CUR_W    = 8,
  parameter int DT_SHIFT = 1,
  localparam int AW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                cur_we,
  input  logic [AW-1:0]       cur_addr,
  input  logic [CUR_W-1:0]    cur_data,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [1:0]          cfg_mode,
  input  logic [AW-1:0]       obs_sel,
  output logic signed [W-1:0] obs_v,
  output logic [N-1:0]        spike,
  output logic                busy,
  output logic                done
);

  localparam logic signed [W-1:0] V_RST_FX = W'(V_REST * (2 ** F));
  localparam logic signed [W-1:0] U_RST_FX = V_RST_FX >>> 2;

  logic signed [W-1:0] v_mem   [N];
  logic signed [W-1:0] u_mem   [N];
  logic [CUR_W-1:0]    cur_mem [N];
  izh_mode_e           mode_mem[N];

  izh_state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic start, do_latch, do_write, do_fin;

  logic signed [W-1:0]   v_p, u_p;
  logic signed [2*W-1:0] vv_p;
  logic [CUR_W-1:0]      cur_p;
  izh_mode_e             mode_p;
  logic [N-1:0]          spike_shadow;

  logic signed [W-1:0] v_new, u_new;
  logic                fired;

  izh_core #(
    .W        (W),
    .F        (F),
    .CUR_W    (CUR_W),
    .DT_SHIFT (DT_SHIFT)
  ) u_core (
    .v      (v_p),
    .u      (u_p),
    .vv     (vv_p),
    .cur    (cur_p),
    .mode   (mode_p),
    .v_next (v_new),
    .u_next (u_new),
    .fired  (fired)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    start    = 1'b0;
    do_latch = 1'b0;
    do_write = 1'b0;
    do_fin   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_CALC;
          idx_d   = '0;
          start   = 1'b1;
        end
      end
      ST_CALC: begin
        do_latch = 1'b1;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        do_write = 1'b1;
        if (int'(idx_q) == N - 1) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_CALC;
          idx_d   = idx_q + AW'(1);
        end
      end
      ST_FIN: begin
        do_fin  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      spike        <= '0;
      spike_shadow <= '0;
      obs_v        <= V_RST_FX;
      v_p          <= '0;
      u_p          <= '0;
      vv_p         <= '0;
      cur_p        <= '0;
      mode_p       <= MODE_RS;
      for (int i = 0; i < N; i++) begin
        v_mem[i]    <= V_RST_FX;
        u_mem[i]    <= U_RST_FX;
        cur_mem[i]  <= '0;
        mode_mem[i] <= MODE_RS;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done    <= do_fin;

      if (start)  busy <= 1'b1;
      if (do_fin) begin
        busy  <= 1'b0;
        spike <= spike_shadow;
      end

      if (cur_we && (int'(cur_addr) < N)) cur_mem[cur_addr] <= cur_data;
      if (cfg_we && (int'(cfg_addr) < N)) mode_mem[cfg_addr] <= izh_mode_e'(cfg_mode);

      // Array reads here see the old contents, so a write landing on this
      // same edge is not picked up by the neuron being latched.
      if (do_latch) begin
        v_p    <= v_mem[idx_q];
        u_p    <= u_mem[idx_q];
        cur_p  <= cur_mem[idx_q];
        mode_p <= mode_mem[idx_q];
        vv_p   <= (2 * W)'(v_mem[idx_q]) * (2 * W)'(v_mem[idx_q]);
      end

      if (do_write) begin
        v_mem[idx_q]        <= v_new;
        u_mem[idx_q]        <= u_new;
        spike_shadow[idx_q] <= fired;
      end

      if (int'(obs_sel) < N) obs_v <= v_mem[obs_sel];
    end
  end

endmodule

// File: doc/izh_array.md
Name: izh_array

Overview:
- N Izhikevich neurons, time-multiplexed over one shared fixed-point update datapath.
- Per-neuron state (v, u, input current, mode) is held in register arrays.
- A tick input starts one sweep that updates every neuron once, producing a spike vector and a done pulse.
- Successor to the single-neuron izh; sits directly under the Tiny Tapeout top level.

Parameters:
- N, 4: neuron count (1..16).
- W, 16: signed width of v and u.
- F, 4: fraction bits of v and u.
- CUR_W, 8: unsigned current width; applied as current<<F.
- DT_SHIFT, 1: timestep is 2^-DT_SHIFT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  start sweep; honoured only when busy=0
- cur_we  in  1  current write strobe
- cur_addr  in  $clog2(N)  neuron index for current write
- cur_data  in  CUR_W  current value
- cfg_we  in  1  mode write strobe
- cfg_addr  in  $clog2(N)  neuron index for mode write
- cfg_mode  in  2  0=RS, 1=IB, 2=CH, 3=FS
- obs_sel  in  $clog2(N)  observed neuron
- obs_v  out  W  v of obs_sel (registered, 1-cycle latency)
- spike  out  N  spike vector of the last completed sweep
- busy  out  1  sweep in progress
- done  out  1  1-cycle pulse at sweep end

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset); it is sampled only on the clk edge.
- Reset values (sync, any state including mid-sweep, next edge):
  - v[i] = -65<<F (-1040 at F=4); u[i] = v[i]>>>2 (-260).
  - cur[i] = 0; mode[i] = RS.
  - spike = 0; busy = 0; done = 0; obs_v = -1040; FSM to IDLE.
- FSM is IDLE -> CALC -> WRITE -> (CALC for idx+1 | FIN) -> IDLE.
  - IDLE: on tick, idx=0, busy=1.
  - CALC: latch v, u, cur, mode of idx into pipeline registers; register v*v (2W-bit signed).
  - WRITE: compute the update, write v and u for idx, set spike_shadow[idx]. If idx==N-1 go to FIN, else idx+1 and go to CALC.
  - FIN: spike <= spike_shadow; done=1 for 1 cycle; busy=0; go to IDLE.
- Latency: tick at cycle t gives done at t+2N+1. A tick during busy or FIN is ignored, not queued.
- Update arithmetic (signed; intermediates at 2W+2 bits):
  - q = (vv>>>(F+5)) + (vv>>>(F+7)), which approximates 0.04v².
  - dv = q + (v<<2) + v + (140<<F) - u + (cur<<F).
  - du = ((v>>>BSH) - u)>>>ASH.
  - v' = sat_W(v + (dv>>>DT_SHIFT)).
  - u' = sat_W(u + (du>>>DT_SHIFT)).
  - sat_W clamps to [-2^(W-1), 2^(W-1)-1].
- Spike condition: v' >= 30<<F. Then v' = c<<F, u' = sat_W(u + (d<<F)), and spike_shadow[idx] = 1. Otherwise spike_shadow[idx] = 0.
- Mode table (ASH, BSH, c, d):
  - RS: 6, 2, -65, 8
  - IB: 6, 2, -55, 4
  - CH: 6, 2, -50, 2
  - FS: 3, 2, -65, 2
- Current and mode writes:
  - Take effect at the next clk edge.
  - A write to the neuron currently in CALC is seen only if it landed on or before that CALC edge.
  - Same-cycle writes to different arrays are independent.
  - An out-of-range address (>= N) is ignored.
- spike holds its value until the next FIN; the whole vector changes atomically.

Decomposition:
- izh_pkg holds:
  - the mode enum;
  - mode-table constants ASH/BSH/C/D as arrays indexed by mode;
  - the threshold (30) and rest (-65) constants;
  - the sat function.
- izh_core is the combinational update from (v, u, vv, cur, mode) to (v', u', fired).
- izh_array holds the arrays, the FSM and the observation register.

Test Plan:
- Reset, then read obs_v for all indices -> -1040 each; spike=0, busy=0, done=0.
- cur=0, RS, 20 sweeps -> no spike; v stays within [-1200, -900]. done asserts exactly 2N+1 cycles after each tick.
- cur[0]=100, RS, repeated sweeps -> spike[0]=1 within 5 sweeps; obs_v(0) = -1040 after that sweep; u[0] rose by 128; other spike bits stay 0.
- Neuron 0 RS and neuron 1 FS, both cur=30, 200 sweeps -> spike count of neuron 1 exceeds that of neuron 0.
- Tick held high across a sweep -> exactly one done per 2N+2 cycles; no double update.
- Assert reset during WRITE of idx=2 -> next cycle busy=0, all v=-1040, spike=0; a new tick runs a full clean sweep.
